// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI master that drives the SPI-slave RAM subsystem.
// Holds the frame geometry, the RAM opcodes, the controller states and the frame builder.
package spi_ram_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } ram_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SHIFT,
        S_TURN,
        S_CAPTURE,
        S_GAP
    } state_t;

    // rd_data carries no payload, so its data field is sent as zeros
    function automatic logic [FRAME_W-1:0] make_frame(input ram_op_t op,
                                                      input logic [DATA_W-1:0] data);
        return {op, (op == OP_RD_DATA) ? {DATA_W{1'b0}} : data};
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shifter with serial-in capture and a bit counter.
// The same register serialises the outgoing frame and then collects the reply byte.
module spi_shift_reg
    import spi_ram_pkg::*;
#(
    parameter int W = FRAME_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic             msb,
    output logic             msb_next,
    output logic [DATA_W-1:0] capture,
    output logic [CNT_W-1:0] cnt
);

    logic [W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= load_data;
            cnt <= '0;
        end else if (shift_en) begin
            q   <= {q[W-2:0], serial_in};
            cnt <= cnt + 1'b1;
        end
    end

    assign msb      = q[W-1];
    assign msb_next = q[W-2];
    // byte as it will look once the current serial_in bit is taken
    assign capture  = {q[DATA_W-2:0], serial_in};

endmodule

// File: rtl/spi_master_ram_ctrl.sv
// SPI master for the SPI-slave RAM: one command per 10-bit frame, MSB first,
// one bit per clk; rd_data frames capture an 8-bit reply from MISO after a turnaround.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | SS_n high, cmd_ready high, waiting for a command
// S_SELECT  | first SS_n-low cycle, MOSI shows frame[9]
// S_SHIFT   | 10 cycles, MOSI = frame[9-k], k = 0..9
// S_TURN    | rd_data only: RD_TURNAROUND cycles, MOSI low, MISO ignored
// S_CAPTURE | rd_data only: 8 cycles, MISO sampled MSB first
// S_GAP     | SS_n high for IDLE_GAP cycles before returning to IDLE
module spi_master_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int RD_TURNAROUND = 2,
    parameter int IDLE_GAP      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        busy,
    output logic        SS_n,
    output logic        MOSI,
    input  logic        MISO
);

    state_t               state;
    ram_op_t              op_q;
    logic [2:0]           timer;

    logic                 accept;
    logic                 shift_last;
    logic                 cap_last;
    logic                 sr_load;
    logic [FRAME_W-1:0]   sr_load_data;
    logic                 sr_shift;
    logic                 sr_serial;
    logic                 sr_msb;
    logic                 sr_msb_next;
    logic [DATA_W-1:0]    sr_capture;
    logic [CNT_W-1:0]     sr_cnt;

    // ready is forced low while reset is held so commands during reset are never taken
    assign cmd_ready  = (state == S_IDLE) && !rst;
    assign busy       = (state != S_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign shift_last = (state == S_SHIFT)   && (sr_cnt == CNT_W'(FRAME_W - 1));
    assign cap_last   = (state == S_CAPTURE) && (sr_cnt == CNT_W'(DATA_W - 1));

    // rd_data reloads zeros at the end of SHIFT so the capture starts from a clean register
    assign sr_load      = accept || (shift_last && (op_q == OP_RD_DATA));
    assign sr_load_data = accept ? make_frame(ram_op_t'(cmd_op), cmd_data) : '0;
    assign sr_shift     = (state == S_SHIFT) || (state == S_CAPTURE);
    assign sr_serial    = (state == S_CAPTURE) ? MISO : 1'b0;

    spi_shift_reg #(
        .W (FRAME_W)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .load_data (sr_load_data),
        .shift_en  (sr_shift),
        .serial_in (sr_serial),
        .msb       (sr_msb),
        .msb_next  (sr_msb_next),
        .capture   (sr_capture),
        .cnt       (sr_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OP_WR_ADDR;
            timer      <= '0;
            SS_n       <= 1'b1;
            MOSI       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_SELECT;
                        op_q  <= ram_op_t'(cmd_op);
                        SS_n  <= 1'b0;
                        MOSI  <= cmd_op[1];
                    end
                end
                S_SELECT: begin
                    state <= S_SHIFT;
                    MOSI  <= sr_msb;
                end
                S_SHIFT: begin
                    if (shift_last) begin
                        MOSI <= 1'b0;
                        if (op_q == OP_RD_DATA) begin
                            state <= S_TURN;
                            timer <= 3'(RD_TURNAROUND - 1);
                        end else begin
                            state <= S_GAP;
                            SS_n  <= 1'b1;
                            timer <= 3'(IDLE_GAP - 1);
                        end
                    end else begin
                        MOSI <= sr_msb_next;
                    end
                end
                S_TURN: begin
                    if (timer == 3'd0) state <= S_CAPTURE;
                    else               timer <= timer - 3'd1;
                end
                S_CAPTURE: begin
                    if (cap_last) begin
                        state      <= S_GAP;
                        SS_n       <= 1'b1;
                        timer      <= 3'(IDLE_GAP - 1);
                        resp_valid <= 1'b1;
                        resp_data  <= sr_capture;
                    end
                end
                S_GAP: begin
                    if (timer == 3'd0) state <= S_IDLE;
                    else               timer <= timer - 3'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ram_ctrl.sv
// Bench for spi_master_ram_ctrl: per-cycle comparison against a frame-sequence model,
// a RAM-backed SPI slave model, and two extra instances sweeping the read turnaround.
module tb_spi_master_ram_ctrl;

    localparam int TA  = 2;
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_ready, resp_valid, busy, ss_n, mosi, miso;
    logic [7:0] resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_master_ram_ctrl #(.RD_TURNAROUND(TA), .IDLE_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .resp_valid(resp_valid),
        .resp_data(resp_data), .busy(busy), .SS_n(ss_n), .MOSI(mosi), .MISO(miso));

    // turnaround sweep instances: index 0 -> RD_TURNAROUND=1, index 1 -> RD_TURNAROUND=4
    logic       sw_valid [2];
    logic       sw_ready [2];
    logic       sw_rv    [2];
    logic [7:0] sw_rd    [2];
    logic       sw_busy  [2];
    logic       sw_ss    [2];
    logic       sw_mosi  [2];
    logic       sw_miso  [2];
    logic [1:0] sw_op   = 2'b11;
    logic [7:0] sw_data = 8'h00;

    spi_master_ram_ctrl #(.RD_TURNAROUND(1), .IDLE_GAP(1)) u_ta1 (
        .clk(clk), .rst(rst), .cmd_valid(sw_valid[0]), .cmd_ready(sw_ready[0]),
        .cmd_op(sw_op), .cmd_data(sw_data), .resp_valid(sw_rv[0]),
        .resp_data(sw_rd[0]), .busy(sw_busy[0]), .SS_n(sw_ss[0]), .MOSI(sw_mosi[0]),
        .MISO(sw_miso[0]));

    spi_master_ram_ctrl #(.RD_TURNAROUND(4), .IDLE_GAP(3)) u_ta4 (
        .clk(clk), .rst(rst), .cmd_valid(sw_valid[1]), .cmd_ready(sw_ready[1]),
        .cmd_op(sw_op), .cmd_data(sw_data), .resp_valid(sw_rv[1]),
        .resp_data(sw_rd[1]), .busy(sw_busy[1]), .SS_n(sw_ss[1]), .MOSI(sw_mosi[1]),
        .MISO(sw_miso[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: expected per-cycle pin sequence ----------------
    typedef struct {
        logic       ss_n;
        logic       mosi;
        logic       rv;
        logic       apply;
        logic [1:0] op;
        logic [7:0] d;
    } exp_t;

    exp_t       q_exp[$];
    logic [7:0] m_mem [256];
    logic [7:0] m_waddr = 8'h00, m_raddr = 8'h00, m_rdval = 8'h00, exp_resp = 8'h00;
    bit         force_81 = 1'b0;

    task automatic push_frame(input logic [1:0] op, input logic [7:0] d);
        logic [9:0] fr;
        exp_t       e;
        fr      = {op, (op == 2'b11) ? 8'h00 : d};
        e.ss_n  = 1'b0; e.rv = 1'b0; e.apply = 1'b0; e.op = op; e.d = d;
        e.mosi  = fr[9];
        q_exp.push_back(e);
        for (int k = 9; k >= 0; k--) begin
            e.mosi  = fr[k];
            e.apply = (k == 0);
            q_exp.push_back(e);
        end
        e.apply = 1'b0;
        e.mosi  = 1'b0;
        if (op == 2'b11)
            for (int k = 0; k < TA + 8; k++) q_exp.push_back(e);
        e.ss_n = 1'b1;
        for (int k = 0; k < GAP; k++) begin
            e.rv = (op == 2'b11) && (k == 0);
            q_exp.push_back(e);
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        bit   idle;
        if (rst) begin
            q_exp.delete();
            exp_resp = 8'h00;
            chk("rst_ss_n",       32'(ss_n),       32'd1);
            chk("rst_mosi",       32'(mosi),       32'd0);
            chk("rst_cmd_ready",  32'(cmd_ready),  32'd0);
            chk("rst_busy",       32'(busy),       32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_data",  32'(resp_data),  32'd0);
        end else begin
            if (q_exp.size() > 0) begin
                e    = q_exp.pop_front();
                idle = 1'b0;
            end else begin
                e.ss_n = 1'b1; e.mosi = 1'b0; e.rv = 1'b0; e.apply = 1'b0;
                e.op = 2'b00; e.d = 8'h00;
                idle = 1'b1;
            end
            if (e.apply) begin
                case (e.op)
                    2'b00: m_waddr = e.d;
                    2'b01: m_mem[m_waddr] = e.d;
                    2'b10: m_raddr = e.d;
                    default: m_rdval = force_81 ? 8'h81 : m_mem[m_raddr];
                endcase
            end
            if (e.rv) exp_resp = m_rdval;
            chk("ss_n",       32'(ss_n),       32'(e.ss_n));
            chk("mosi",       32'(mosi),       32'(e.mosi));
            chk("resp_valid", 32'(resp_valid), 32'(e.rv));
            chk("resp_data",  32'(resp_data),  32'(exp_resp));
            chk("busy",       32'(busy),       32'(!idle));
            chk("cmd_ready",  32'(cmd_ready),  32'(idle));
            if (cmd_valid && idle) push_frame(cmd_op, cmd_data);
        end
    end

    // ---------------- SPI slave with RAM (loopback) for the main instance ----------------
    logic [7:0] ram [256];
    logic [9:0] s_sh = 10'h0;
    logic [7:0] s_waddr = 8'h00, s_raddr = 8'h00, s_rdbyte = 8'h00;
    int         s_j = 0;

    always @(negedge clk) begin : slave
        if (ss_n) begin
            s_j  = 0;
            miso = 1'($urandom_range(0, 1));
        end else begin
            if (s_j >= 1 && s_j <= 10) s_sh = {s_sh[8:0], mosi};
            if (s_j == 10) begin
                case (s_sh[9:8])
                    2'b00: s_waddr = s_sh[7:0];
                    2'b01: ram[s_waddr] = s_sh[7:0];
                    2'b10: s_raddr = s_sh[7:0];
                    default: s_rdbyte = force_81 ? 8'h81 : ram[s_raddr];
                endcase
            end
            if (s_j >= 11 + TA && s_j < 19 + TA) miso = s_rdbyte[7 - (s_j - 11 - TA)];
            else                                 miso = 1'($urandom_range(0, 1));
            s_j++;
        end
    end

    // frame recorder on the main instance's pins
    logic [31:0] rec = 0, last_bits = 0;
    int          rec_len = 0, last_len = 0, n_resp = 0;

    always @(negedge clk) begin : recorder
        if (rst) begin
            rec = 0; rec_len = 0;
        end else begin
            if (resp_valid) n_resp++;
            if (!ss_n) begin
                rec = {rec[30:0], mosi};
                rec_len++;
            end else if (rec_len > 0) begin
                last_bits = rec; last_len = rec_len;
                rec = 0; rec_len = 0;
            end
        end
    end

    // ---------------- sweep slaves / monitors ----------------
    logic [7:0] sw_pat [2];
    int         sw_j [2];
    int         sw_cnt [2];

    always @(negedge clk) begin : sweep_mon
        int ta;
        for (int k = 0; k < 2; k++) begin
            ta = (k == 0) ? 1 : 4;
            if (rst) begin
                sw_j[k]    = 0;
                sw_miso[k] = 1'b0;
            end else if (!sw_ss[k]) begin
                if (sw_j[k] >= 11 + ta && sw_j[k] < 19 + ta)
                    sw_miso[k] = sw_pat[k][7 - (sw_j[k] - 11 - ta)];
                else
                    sw_miso[k] = 1'($urandom_range(0, 1));
                sw_j[k]++;
            end else begin
                if (sw_rv[k]) begin
                    chk("sw_rv_low_cycles", 32'(sw_j[k]), 32'(19 + ta));
                    chk("sw_resp_data",     32'(sw_rd[k]), 32'(sw_pat[k]));
                    sw_cnt[k]++;
                end
                sw_j[k]    = 0;
                sw_miso[k] = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] op, input logic [7:0] d, input bit keep);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        chk("send_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!busy && q_exp.size() == 0) ok = 1'b1;
        end
        chk("idle_reached", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic sweep_read(input int k, input logic [7:0] pat);
        bit ok;
        int n0;
        sw_pat[k]   = pat;
        n0          = sw_cnt[k];
        ok          = 1'b0;
        sw_valid[k] = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (sw_ready[k]) ok = 1'b1;
        end
        chk("sw_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        sw_valid[k] = 1'b0;
        for (int i = 0; i < 60 && sw_cnt[k] == n0; i++) @(negedge clk);
        chk("sw_resp_count", 32'(sw_cnt[k] - n0), 32'd1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = 8'(i * 7 + 3);
            ram[i]   = 8'(i * 7 + 3);
        end
        sw_cnt[0] = 0; sw_cnt[1] = 0;
        sw_pat[0] = 8'h00; sw_pat[1] = 8'h00;
        sw_valid[0] = 1'b0; sw_valid[1] = 1'b0;
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'hFF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; cmd_valid = 1'b0;

        // idle for 50 cycles
        repeat (50) @(posedge clk);
        #1;

        // write 0xA5 to 0x3C
        send(2'b00, 8'h3C, 1'b0);
        wait_idle();
        chk("wr_addr_len",  32'(last_len), 32'd11);
        chk("wr_addr_bits", last_bits & 32'h7FF, 32'b000_0011_1100);
        send(2'b01, 8'hA5, 1'b0);
        wait_idle();
        chk("wr_data_len",  32'(last_len), 32'd11);
        chk("wr_data_bits", last_bits & 32'h7FF, 32'b001_1010_0101);
        chk("ram_3c",       32'(ram[8'h3C]), 32'hA5);

        // read it back
        send(2'b10, 8'h3C, 1'b0);
        wait_idle();
        n0 = n_resp;
        send(2'b11, 8'h77, 1'b0);
        wait_idle();
        chk("rd_data_len",    32'(last_len), 32'd21);
        chk("rd_resp_data",   32'(resp_data), 32'hA5);
        chk("rd_resp_pulses", 32'(n_resp - n0), 32'd1);

        // back-to-back with cmd_valid held high
        send(2'b00, 8'h10, 1'b1);
        send(2'b01, 8'h5A, 1'b1);
        send(2'b10, 8'h10, 1'b1);
        send(2'b11, 8'h00, 1'b0);
        wait_idle();
        chk("stress_resp", 32'(resp_data), 32'h5A);

        // standalone slave returning 0x81
        force_81 = 1'b1;
        send(2'b11, 8'h00, 1'b0);
        wait_idle();
        chk("miso_81", 32'(resp_data), 32'h81);
        force_81 = 1'b0;

        // turnaround sweep
        sweep_read(0, 8'h81);
        sweep_read(1, 8'h81);
        sweep_read(0, 8'($urandom_range(0, 255)));
        sweep_read(1, 8'($urandom_range(0, 255)));

        // reset during SHIFT k=5
        n0 = n_resp;
        send(2'b00, 8'h3C, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ss_n",  32'(ss_n),      32'd1);
        chk("midrst_busy",  32'(busy),      32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        send(2'b01, 8'h00, 1'b0);
        wait_idle();
        chk("post_rst_len",   32'(last_len), 32'd11);
        chk("post_rst_ram",   32'(ram[8'h10]), 32'h00);
        chk("midrst_no_resp", 32'(n_resp - n0), 32'd0);

        // randomized traffic over a small address window
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            logic [7:0] d;
            bit         keep;
            op   = 2'($urandom_range(0, 3));
            d    = (op == 2'b00 || op == 2'b10) ? 8'($urandom_range(0, 7))
                                                : 8'($urandom_range(0, 255));
            keep = (i != 59) && ($urandom_range(0, 3) == 0);
            send(op, d, keep);
            if (!keep) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
